// File: rtl/bram_playback_engine_pkg.sv
// Shared types and constants for the BRAM playback engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bram_playback_engine_pkg;

    // Engine control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Supported range for the BRAM read pipeline depth.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // The output FIFO holds every read the pipeline can have outstanding, plus one line
    // being presented. That lets a read issue every cycle without losing data.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 1;
    endfunction

endpackage

// File: rtl/bram_playback_engine_if.sv
// Bundles the write port, clear, playback control and line stream of the playback engine.
// Latency: n/a (wiring only).
// Backpressure: line stream is valid/ready; writes and clear are gated by write_rdy.
interface bram_playback_engine_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_W     = 10
);
    // Line write port and clear request.
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  clr;
    logic                  write_rdy;

    // Playback control.
    logic                  gen_en;
    logic                  loop_mode;
    logic [ADDR_W:0]       play_len;
    logic                  done;

    // Played-back line stream.
    logic [DATA_WIDTH-1:0] line_out;
    logic [ADDR_W-1:0]     line_addr;
    logic                  line_valid;
    logic                  line_last;
    logic                  line_ready;

    modport master (
        output wr_en, wr_addr, wr_data, clr, gen_en, loop_mode, play_len, line_ready,
        input  write_rdy, done, line_out, line_addr, line_valid, line_last
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, clr, gen_en, loop_mode, play_len, line_ready,
        output write_rdy, done, line_out, line_addr, line_valid, line_last
    );

endinterface

// File: rtl/bram_playback_engine_fifo.sv
// Small register FIFO that buffers prefetched playback lines ahead of the consumer.
// Latency: one cycle from push to the entry being visible at the head.
// Backpressure: the caller must not push when full or pop when empty; flush empties it at once.
module playback_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    // Pointers wrap explicitly, so DEPTH does not have to be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Storage and pointer update. Storage is reset to zero so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                storage_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q            <= ptr_next(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            if (push_i && !pop_i) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!push_i && pop_i) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign pop_dat_o = storage_q[rd_ptr_q];
    assign empty_o   = (cnt_q == '0);
    assign count_o   = cnt_q;

endmodule

// File: rtl/bram_playback_engine.sv
// Plays stored lines out of a BRAM as a stream, one-shot or looping, with a clear sweep.
// Latency: first line appears READ_LATENCY+1 cycles after playback starts, then one line per cycle.
// Backpressure: line_ready stalls the stream; reads are credit-limited by the output FIFO depth.
module bram_playback_engine
    import bram_playback_engine_pkg::*;
#(
    parameter int DATA_WIDTH   = 256,
    parameter int BRAM_DEPTH   = 1024,
    parameter int READ_LATENCY = 2    // legal range RD_LAT_MIN..RD_LAT_MAX
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bram_playback_engine_if.slave bus
);
    localparam int ADDR_W     = $clog2(BRAM_DEPTH);
    localparam int FIFO_DEPTH = fifo_depth(READ_LATENCY);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W    = DATA_WIDTH + ADDR_W + 1;
    localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W + 1)'(BRAM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BRAM_DEPTH - 1);

    state_t state_q, state_d;

    // Playback bookkeeping.
    logic [ADDR_W-1:0]     clr_addr_q;
    logic [ADDR_W:0]       len_q;
    logic                  loop_q;
    logic [ADDR_W-1:0]     rd_ptr_q;
    logic                  stop_q;       // one-shot pass fully issued

    // Read pipeline side-band. The data path travels in pipe_dat_q next to the memory.
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [READ_LATENCY-1:0] pipe_last_q;
    logic [ADDR_W-1:0]       pipe_addr_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   pipe_dat_q  [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   mem_q       [BRAM_DEPTH];

    // Combinational control.
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdat;
    logic                  rd_issue;
    logic                  rd_is_last;
    logic                  flush;
    logic                  start;
    logic                  pop;
    logic                  line_vld;
    logic [ADDR_W:0]       len_eff;

    // FIFO signals.
    logic [ENTRY_W-1:0]    fifo_head;
    logic [ENTRY_W-1:0]    fifo_push_dat;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_cnt;

    assign len_eff    = (bus.play_len > DEPTH_LEN) ? DEPTH_LEN : bus.play_len;
    assign rd_is_last = ({1'b0, rd_ptr_q} == (len_q - (ADDR_W + 1)'(1)));
    assign line_vld   = (state_q == ST_PLAY) && !fifo_empty;
    assign pop        = line_vld && bus.line_ready;

    // Next state, memory write mux and read issue. A read issues only while the FIFO
    // entries, the reads in flight and the new read fit in the FIFO. An entry that pops
    // this cycle frees its slot for the new read, which keeps a full-rate stream.
    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdat  = bus.wr_data;
        rd_issue  = 1'b0;
        flush     = 1'b0;
        start     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.clr) begin
                    state_d = ST_CLEAR;              // clear wins, same-cycle write dropped
                end else begin
                    mem_we = bus.wr_en;
                    if (bus.gen_en && (len_eff != '0)) begin
                        state_d = ST_PLAY;
                        start   = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
                mem_wdat  = '0;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (!bus.gen_en) begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                end else begin
                    rd_issue = !stop_q &&
                               ((int'(fifo_cnt) + $countones(pipe_vld_q)) < (FIFO_DEPTH + int'(pop)));
                    if (pop && fifo_head[ENTRY_W-1] && !loop_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!bus.gen_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear sweep address, playback parameters latched at start, and read address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr_q <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            rd_ptr_q   <= '0;
            stop_q     <= 1'b0;
        end else begin
            if (state_q == ST_CLEAR) begin
                clr_addr_q <= clr_addr_q + 1'b1;
            end else begin
                clr_addr_q <= '0;
            end
            if (start) begin
                len_q    <= len_eff;
                loop_q   <= bus.loop_mode;
                rd_ptr_q <= '0;
                stop_q   <= 1'b0;
            end else if (rd_issue) begin
                if (rd_is_last) begin
                    rd_ptr_q <= '0;
                    stop_q   <= !loop_q;
                end else begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    // Simple dual-port memory with a registered read, followed by the extra read stages.
    // No reset here, so neither reset nor playback touches the stored lines.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdat;
        end
        if (rd_issue) begin
            pipe_dat_q[0] <= mem_q[rd_ptr_q];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_dat_q[i] <= pipe_dat_q[i-1];
        end
    end

    // Valid, address and last tags that travel alongside the read data. An abort drops them all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_addr_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= rd_issue;
            pipe_last_q[0] <= rd_is_last;
            pipe_addr_q[0] <= rd_ptr_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end
            if (flush) begin
                pipe_vld_q <= '0;
            end
        end
    end

    assign fifo_push_dat = {pipe_last_q[READ_LATENCY-1],
                            pipe_addr_q[READ_LATENCY-1],
                            pipe_dat_q[READ_LATENCY-1]};

    playback_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FIFO_CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .push_i     (pipe_vld_q[READ_LATENCY-1] && !flush),
        .push_dat_i (fifo_push_dat),
        .pop_i      (pop),
        .pop_dat_o  (fifo_head),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    // The FIFO head is held until it is popped, so the outputs stay stable under a stall.
    assign bus.line_out   = fifo_head[DATA_WIDTH-1:0];
    assign bus.line_addr  = fifo_head[DATA_WIDTH +: ADDR_W];
    assign bus.line_last  = fifo_head[ENTRY_W-1];
    assign bus.line_valid = line_vld;
    assign bus.write_rdy  = (state_q == ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_bram_playback_engine.sv
// Directed bench for the BRAM playback engine.
// Latency: checks the first-line delay and the full-rate stream.
// Backpressure: drives line_ready both held high and randomly toggled.
module tb_bram_playback_engine;
    localparam int DW    = 64;
    localparam int DEPTH = 32;
    localparam int RL    = 2;
    localparam int AW    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bram_playback_engine_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

    bram_playback_engine #(
        .DATA_WIDTH   (DW),
        .BRAM_DEPTH   (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [DW-1:0] ref_mem [DEPTH];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {valid, last, addr, data} for the line at address a.
    function automatic logic [127:0] beat(input int a, input bit last);
        logic [AW-1:0] aa;
        aa = a[AW-1:0];
        return {57'b0, 1'b1, last, aa, ref_mem[a]};
    endfunction

    function automatic logic [127:0] obs_beat();
        return {57'b0, bus.line_valid, bus.line_last, bus.line_addr, bus.line_out};
    endfunction

    task automatic wait_first(input int budget, input string tag);
        int n = 0;
        while (!bus.line_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_first_timeout"}, {127'b0, bus.line_valid}, 128'd1);
    endtask

    // n consecutive beats with line_ready high, starting at the current negedge.
    task automatic play_stream(input int n, input int len, input string tag);
        for (int b = 0; b < n; b++) begin
            if (b > 0) @(negedge clk);
            check($sformatf("%s_beat%0d", tag, b), obs_beat(), beat(b % len, (b % len) == len - 1));
        end
    endtask

    task automatic abort_play(input string tag);
        @(negedge clk);
        bus.gen_en     = 1'b0;
        bus.line_ready = 1'b0;
        @(negedge clk);
        check({tag, "_abort"}, {126'b0, bus.line_valid, bus.write_rdy}, 128'b01);
    endtask

    task automatic start_play(input int len, input bit lp);
        bus.play_len   = (AW + 1)'(len);
        bus.loop_mode  = lp;
        bus.line_ready = 1'b1;
        bus.gen_en     = 1'b1;
    endtask

    initial begin
        int n;
        int exp_idx;

        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.clr        = 1'b0;
        bus.gen_en     = 1'b0;
        bus.loop_mode  = 1'b0;
        bus.play_len   = '0;
        bus.line_ready = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_valid", {127'b0, bus.line_valid}, 128'd0);
        check("rst_last",  {127'b0, bus.line_last},  128'd0);
        check("rst_done",  {127'b0, bus.done},       128'd0);
        check("rst_addr",  {123'b0, bus.line_addr},  128'd0);
        check("rst_out",   {64'b0, bus.line_out},    128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_write_rdy", {127'b0, bus.write_rdy}, 128'd1);

        // Fill the whole memory with random lines.
        for (int a = 0; a < DEPTH; a++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(a);
            bus.wr_data = {$urandom, $urandom};
            ref_mem[a]  = bus.wr_data;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;

        // play_len = 0 keeps the block idle.
        start_play(0, 1'b1);
        repeat (6) begin
            @(negedge clk);
            check("len0_idle", {126'b0, bus.line_valid, bus.write_rdy}, 128'b01);
        end
        bus.gen_en = 1'b0;
        @(negedge clk);

        // Looping, ready held high: first-line latency, then 48 gap-free beats.
        start_play(16, 1'b1);
        for (int i = 1; i <= RL + 2; i++) begin
            @(negedge clk);
            check($sformatf("lat_cycle%0d", i), {127'b0, bus.line_valid}, {127'b0, (i == RL + 2)});
        end
        play_stream(48, 16, "loop16");
        abort_play("loop16");

        // Looping with random backpressure: in order, held under stall, nothing lost.
        start_play(16, 1'b1);
        exp_idx = 0;
        n = 0;
        while (exp_idx < 40 && n < 600) begin
            @(negedge clk);
            n++;
            bus.line_ready = 1'($urandom_range(0, 1));
            if (bus.line_valid) begin
                check($sformatf("bp_beat%0d", exp_idx), obs_beat(),
                      beat(exp_idx % 16, (exp_idx % 16) == 15));
                if (bus.line_ready) exp_idx++;
            end
        end
        check("bp_budget", 128'(exp_idx), 128'd40);
        abort_play("bp");

        // One-shot of 5 lines, then DONE until gen_en drops.
        start_play(5, 1'b0);
        wait_first(10, "oneshot");
        play_stream(5, 5, "oneshot");
        repeat (4) begin
            @(negedge clk);
            check("oneshot_done", {126'b0, bus.line_valid, bus.done}, 128'b01);
        end
        bus.gen_en = 1'b0;
        @(negedge clk);
        check("oneshot_idle", {126'b0, bus.done, bus.write_rdy}, 128'b01);

        // Abort after 7 beats, restart from address 0.
        start_play(16, 1'b1);
        wait_first(10, "abort7");
        play_stream(7, 16, "abort7");
        abort_play("abort7");
        start_play(16, 1'b1);
        wait_first(10, "restart");
        play_stream(3, 16, "restart");
        abort_play("restart");

        // Over-long play_len clips to the memory depth and wraps after the last line.
        start_play(DEPTH + 3, 1'b1);
        wait_first(10, "clip");
        play_stream(DEPTH + 3, DEPTH, "clip");
        abort_play("clip");

        // Reset in the middle of playback; stored data survives.
        start_play(16, 1'b1);
        wait_first(10, "midrst");
        play_stream(4, 16, "midrst");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {127'b0, bus.line_valid}, 128'd0);
        bus.gen_en     = 1'b0;
        bus.line_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", {126'b0, bus.done, bus.write_rdy}, 128'b01);
        start_play(16, 1'b1);
        wait_first(10, "postrst");
        play_stream(16, 16, "postrst");
        abort_play("postrst");

        // Clear with a colliding write, then another write attempted during the sweep.
        bus.clr     = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(3);
        bus.wr_data = '1;
        @(negedge clk);
        bus.clr   = 1'b0;
        bus.wr_en = 1'b0;
        n = 0;
        while (!bus.write_rdy && n < DEPTH + 10) begin
            bus.wr_en   = (n == 5);
            bus.wr_addr = '0;
            bus.wr_data = '1;
            n++;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check("clr_busy_cycles", 128'(n), 128'(DEPTH));
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        start_play(DEPTH, 1'b0);
        wait_first(10, "zeros");
        play_stream(DEPTH, DEPTH, "zeros");
        @(negedge clk);
        check("zeros_done", {126'b0, bus.line_valid, bus.done}, 128'b01);
        bus.gen_en = 1'b0;
        @(negedge clk);
        check("zeros_idle", {127'b0, bus.write_rdy}, 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bram_playback_engine.md
BRAM_PLAYBACK_ENGINE -- requirements
Module: bram_playback_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, playback line width in bits (multiple of 32).
REQ-002 SHALL have parameter BRAM_DEPTH, default 1024, number of lines (power of two); ADDR_W = $clog2(BRAM_DEPTH).
REQ-003 SHALL have parameter READ_LATENCY, default 2, BRAM read pipeline depth in cycles (1..4).
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports wr_en, input, 1; wr_addr, input, ADDR_W; and wr_data, input, DATA_WIDTH, together forming the line write port.
REQ-007 SHALL have port clr, input, 1, one-cycle request to zero the whole memory.
REQ-008 SHALL have port write_rdy, output, 1, high when writes and clear are accepted.
REQ-009 SHALL have port gen_en, input, 1, level that enables playback.
REQ-010 SHALL have port loop_mode, input, 1, 1 = repeat forever, 0 = one-shot; sampled at playback start.
REQ-011 SHALL have port play_len, input, ADDR_W+1, number of lines to play from address 0; sampled at playback start.
REQ-012 SHALL have ports line_out, output, DATA_WIDTH; line_addr, output, ADDR_W; line_valid, output, 1; and line_last, output, 1 (final line of a pass).
REQ-013 SHALL have port line_ready, input, 1, consumer accepts the line when line_valid and line_ready are both high.
REQ-014 SHALL have port done, output, 1, high in the DONE state.

Function
REQ-015 SHALL implement states IDLE, CLEAR, PLAY, DONE.
REQ-016 SHALL drive write_rdy = 1 only in IDLE; wr_en and clr SHALL be ignored in every other state.
REQ-017 In IDLE, clr SHALL enter CLEAR, writing zero to one address per cycle from 0 to BRAM_DEPTH-1, then return to IDLE (BRAM_DEPTH cycles total).
REQ-018 clr SHALL win over wr_en in the same cycle; that write SHALL be dropped.
REQ-019 In IDLE with gen_en=1 and effective length L>0, the block SHALL latch L and loop_mode and enter PLAY; L = min(play_len, BRAM_DEPTH).
REQ-020 If play_len=0, gen_en SHALL keep the block in IDLE with line_valid=0.
REQ-021 The first line_valid SHALL assert exactly READ_LATENCY+1 cycles after the IDLE->PLAY transition.
REQ-022 Lines SHALL be presented at addresses 0,1,...,L-1, with line_addr equal to the source address of line_out.
REQ-023 Once line_valid is asserted, line_out, line_addr and line_last SHALL hold stable until the handshake completes.
REQ-024 With line_ready held at 1, the block SHALL sustain one line per cycle with no bubbles, including across the wrap from L-1 to 0.
REQ-025 Reads SHALL be prefetched into an output FIFO of depth READ_LATENCY+1; a read SHALL issue only if FIFO occupancy plus in-flight reads is below that depth, so no data is ever lost.
REQ-026 line_last SHALL be 1 exactly when line_addr = L-1.
REQ-027 In loop mode, address L-1 SHALL be followed by address 0 indefinitely.
REQ-028 In one-shot mode, after the handshake of line L-1 the block SHALL enter DONE with line_valid=0 and done=1.
REQ-029 From DONE, gen_en=0 SHALL return the block to IDLE.
REQ-030 gen_en=0 in PLAY SHALL abort on the next cycle: FIFO and in-flight reads flushed, line_valid=0, return to IDLE; the next playback SHALL restart at address 0.
REQ-031 Memory contents SHALL NOT be altered by reset or playback.

Reset
REQ-032 rst_n low SHALL set: state IDLE, write_rdy=1 after release, line_valid=0, line_last=0, done=0, line_addr=0, line_out=0, FIFO empty, counters 0.
REQ-033 Reset during CLEAR SHALL abort the sweep; the memory is left partially cleared.

Structure
REQ-034 A shared package SHALL hold the state enum and READ_LATENCY bound constants.
REQ-035 The output FIFO SHALL be a sub-module, playback_fifo, parametrised by width and depth.
REQ-036 Memory SHALL be inferred as simple dual-port BRAM with registered output.

Verification
REQ-037 Write 16 random lines, play_len=16, loop_mode=1, line_ready=1 -> 48 consecutive beats matching addresses 0..15 three times, line_last on every 16th beat.
REQ-038 Same data, line_ready randomly toggled -> every beat matches, with no duplicate and no skipped line.
REQ-039 play_len=5, loop_mode=0 -> exactly 5 beats at addresses 0..4; done=1 afterwards; gen_en=0 -> IDLE with write_rdy=1.
REQ-040 clr after writes -> write_rdy low for BRAM_DEPTH cycles; playback of play_len=BRAM_DEPTH returns all zeros.
REQ-041 gen_en dropped after 7 beats, then re-raised -> next first beat is address 0 with correct data; play_len=BRAM_DEPTH+3 -> wrap after address BRAM_DEPTH-1.
REQ-042 rst_n asserted mid-PLAY -> line_valid=0 immediately; data previously written is intact on the next playback.
